// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store with a fetch starvation guard
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                err_spur
);
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;
  state_t state, state_nxt;
  logic [3:0] starve_cnt;
  logic starved;
  // pick a winner in IDLE, mirror it onto the memory port and advance the FSM
  always_comb begin
    starved = i_req && starve_cnt == 4'(STARVE_MAX);
    d_gnt = rst_n && state == IDLE && d_req && !starved;
    i_gnt = rst_n && state == IDLE && i_req && !d_gnt;
    m_req = i_gnt || d_gnt;
    m_we = d_gnt && d_we;
    m_be = d_gnt ? d_be : i_gnt ? '1 : '0;
    m_addr = d_gnt ? d_addr : i_gnt ? i_addr : '0;
    m_wdata = d_gnt ? d_wdata : '0;
    state_nxt = d_gnt ? WAIT_D : i_gnt ? WAIT_I : (state != IDLE && m_rvalid) ? IDLE : state;
  end
  // state register, response routing, starvation counter and spurious-response flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      starve_cnt <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      err_spur <= 1'b0;
    end else begin
      state <= state_nxt;
      i_rvalid <= state == WAIT_I && m_rvalid;
      d_rvalid <= state == WAIT_D && m_rvalid;
      if (state == WAIT_I && m_rvalid) i_rdata <= m_rdata;
      if (state == WAIT_D && m_rvalid) d_rdata <= m_rdata;
      if (state == IDLE && m_rvalid) err_spur <= 1'b1;
      if (i_gnt || !i_req) starve_cnt <= '0;
      else if (d_gnt && starve_cnt != 4'(STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, SM = 4;
  logic clk = 0, rst_n = 0;
  logic i_req = 0, d_req = 0, d_we = 0, m_rvalid = 0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, m_rdata = '0;
  logic [DW/8-1:0] d_be = '0;
  logic i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, err_spur;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [DW/8-1:0] m_be;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err_spur(err_spur)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit busy = 0, owner_d = 0, e_irv = 0, e_drv = 0, e_err = 0, e_dg = 0, e_ig = 0;
  logic [DW-1:0] e_ird = '0, e_drd = '0, fixed_dat = '0;
  int streak = 0, mem_wait = 0, mem_lat = 0, mode = 0;
  bit fix_dat = 0, spur = 0, got_i = 0, got_d = 0;
  string seq = "";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
    end
  endtask

  // one clock: drive environment, compare against model, then advance model at the edge
  task automatic cycle();
    m_rvalid = spur;
    m_rdata = '0;
    if (mem_wait > 0) begin
      mem_wait--;
      if (mem_wait == 0) begin
        m_rvalid = 1;
        m_rdata = fix_dat ? fixed_dat : $urandom;
      end
    end
    if (mode != 0) begin
      if (got_i || !i_req) begin
        i_req = mode == 2 || $urandom_range(0, 2) != 0;
        i_addr = $urandom & ~32'h3;
      end
      if (got_d || !d_req) begin
        d_req = mode == 2 || $urandom_range(0, 2) != 0;
        d_we = 1'($urandom);
        d_be = 4'($urandom);
        d_addr = $urandom & ~32'h3;
        d_wdata = $urandom;
      end
    end else begin
      if (got_i) i_req = 0;
      if (got_d) d_req = 0;
    end
    #1;
    e_dg = rst_n && !busy && d_req && !(i_req && streak >= SM);
    e_ig = rst_n && !busy && i_req && !e_dg;
    chk("d_gnt", d_gnt, e_dg);
    chk("i_gnt", i_gnt, e_ig);
    chk("m_req", m_req, e_dg | e_ig);
    chk("m_we", m_we, e_dg & d_we);
    chk("m_be", m_be, e_dg ? d_be : e_ig ? 4'hF : 4'h0);
    chk("m_addr", m_addr, e_dg ? d_addr : e_ig ? i_addr : 32'h0);
    chk("m_wdata", m_wdata, e_dg ? d_wdata : 32'h0);
    chk("i_rvalid", i_rvalid, e_irv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("i_rdata", i_rdata, e_ird);
    chk("d_rdata", d_rdata, e_drd);
    chk("err_spur", err_spur, e_err);
    if (i_gnt === 1'b1) seq = {seq, "I"};
    if (d_gnt === 1'b1) seq = {seq, "D"};
    @(posedge clk);
    got_i = e_ig;
    got_d = e_dg;
    if (!rst_n) begin
      busy = 0; streak = 0; e_irv = 0; e_drv = 0; e_ird = '0; e_drd = '0; e_err = 0;
    end else begin
      e_irv = busy && !owner_d && m_rvalid;
      e_drv = busy && owner_d && m_rvalid;
      if (e_irv) e_ird = m_rdata;
      if (e_drv) e_drd = m_rdata;
      if (!busy && m_rvalid) e_err = 1;
      if (busy && m_rvalid) busy = 0;
      if (e_dg || e_ig) begin
        busy = 1;
        owner_d = e_dg;
        mem_wait = mem_lat != 0 ? mem_lat : $urandom_range(1, 3);
      end
      streak = (e_ig || !i_req) ? 0 : streak + int'(e_dg);
    end
    @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);
    i_req = 1; d_req = 1;
    cycle(); cycle();
    #1;
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_err", err_spur, 0);
    i_req = 0; d_req = 0; rst_n = 1;
    cycle();
    i_req = 1; i_addr = 32'h100; mem_lat = 2; fix_dat = 1; fixed_dat = 32'h00500093;
    #1;
    chk("fetch_gnt", i_gnt, 1);
    chk("fetch_addr", m_addr, 32'h100);
    chk("fetch_we", m_we, 0);
    cycle(); cycle(); cycle();
    #1;
    chk("fetch_rvalid", i_rvalid, 1);
    chk("fetch_rdata", i_rdata, 32'h00500093);
    chk("fetch_d_rvalid", d_rvalid, 0);
    cycle();
    fix_dat = 0; mem_lat = 0; seq = "";
    i_req = 1; d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    #1;
    chk("cont_d_gnt", d_gnt, 1);
    chk("cont_i_gnt", i_gnt, 0);
    chk("cont_be", m_be, 4'b0011);
    chk("cont_wdata", m_wdata, 32'hDEADBEEF);
    repeat (10) cycle();
    chk_str("cont_order", seq, "DI");
    mode = 1;
    repeat (500) cycle();
    mode = 0; i_req = 0; d_req = 0;
    repeat (6) cycle();
    mode = 2; mem_lat = 1; seq = "";
    repeat (40) cycle();
    chk_str("starve_order", seq.substr(0, 9), "DDDDIDDDDI");
    mode = 0; i_req = 0; d_req = 0; mem_lat = 0;
    repeat (6) cycle();
    spur = 1;
    cycle();
    spur = 0;
    #1;
    chk("spur_err", err_spur, 1);
    chk("spur_irv", i_rvalid, 0);
    chk("spur_drv", d_rvalid, 0);
    repeat (3) cycle();
    chk("spur_sticky", err_spur, 1);
    rst_n = 0;
    cycle();
    rst_n = 1;
    d_req = 1; d_we = 0; d_addr = 32'h3000; mem_lat = 4;
    cycle(); cycle();
    rst_n = 0;
    cycle();
    rst_n = 1; mem_lat = 0;
    repeat (3) cycle();
    #1;
    chk("rst_mid_err", err_spur, 1);
    chk("rst_mid_drv", d_rvalid, 0);
    d_req = 1; d_addr = 32'h3004;
    #1;
    chk("rst_mid_regnt", d_gnt, 1);
    repeat (6) cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
